// File: rtl/raycast_pkg.sv
// Shared raycaster constants: screen geometry, colours, renderer state encoding.
package raycast_pkg;

    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int CALC_TIMEOUT = 255;

    localparam logic [2:0] CEIL_COLOUR  = 3'b001;
    localparam logic [2:0] WALL_COLOUR  = 3'b111;
    localparam logic [2:0] FLOOR_COLOUR = 3'b010;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_REQ  = 3'd1;
    localparam state_t S_WAIT = 3'd2;
    localparam state_t S_SPAN = 3'd3;
    localparam state_t S_DRAW = 3'd4;
    localparam state_t S_NEXT = 3'd5;

endpackage

// File: rtl/slice_span_calc.sv
// Slice height -> vertical wall span [top, bot). Height is clamped to the
// screen so the span never wraps; an odd leftover row lands on the floor side.
module slice_span_calc
    import raycast_pkg::*;
(
    input  logic [6:0] i_h,
    output logic [7:0] o_top,
    output logic [7:0] o_bot
);

    localparam logic [7:0] H8 = 8'(SCREEN_H);

    logic [7:0] w_h;
    logic [7:0] w_hc;

    assign w_h   = {1'b0, i_h};
    assign w_hc  = (w_h > H8) ? H8 : w_h;
    assign o_top = (H8 - w_hc) >> 1;
    assign o_bot = o_top + w_hc;

endmodule

// File: rtl/slice_column_renderer.sv
// Per-frame column sweep: requests one slice height per column from
// find_slice_height, then plots the column top to bottom (ceiling/wall/floor).
//
//   state  | meaning
//   S_IDLE | waiting for start_frame
//   S_REQ  | one-cycle begin_calc, clear timeout counter
//   S_WAIT | wait for end_calc or timeout, latch height
//   S_SPAN | span derived from latched height, row cleared
//   S_DRAW | one pixel per cycle, rows 0..SCREEN_H-1
//   S_NEXT | advance column or finish frame
module slice_column_renderer
    import raycast_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic       start_frame,
    input  logic [6:0] slice_size,
    input  logic       end_calc,
    output logic       begin_calc,
    output logic [7:0] column_count,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [7:0] COL_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] ROW_LAST = 7'(SCREEN_H - 1);
    localparam logic [7:0] TMO_TC   = 8'(CALC_TIMEOUT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_column;
    logic [6:0] r_row;
    logic [7:0] r_tmo;
    logic [6:0] r_h;
    logic [7:0] r_vga_x;
    logic [2:0] r_colour;
    logic       r_plot;
    logic       r_begin;
    logic       r_busy;
    logic       r_done;

    logic [7:0] w_tmo_inc;
    logic       w_tmo_hit;
    logic       w_col_last;
    logic [7:0] w_top;
    logic [7:0] w_bot;
    logic [7:0] w_row_show;
    logic [2:0] w_colour_nxt;
    logic       w_plot_nxt;
    logic       w_begin_nxt;
    logic       w_busy_nxt;
    logic       w_done_nxt;

    assign w_tmo_inc  = r_tmo + 8'd1;
    assign w_tmo_hit  = (w_tmo_inc == TMO_TC);
    assign w_col_last = (r_column == COL_LAST);

    slice_span_calc u_span (
        .i_h   (r_h),
        .o_top (w_top),
        .o_bot (w_bot)
    );

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state decode; end_calc beats a timeout landing on the same edge
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (start_frame) w_state_nxt = S_REQ;
            S_REQ:  w_state_nxt = S_WAIT;
            S_WAIT: if (end_calc || w_tmo_hit) w_state_nxt = S_SPAN;
            S_SPAN: w_state_nxt = S_DRAW;
            S_DRAW: if (r_row == ROW_LAST) w_state_nxt = S_NEXT;
            S_NEXT: w_state_nxt = w_col_last ? S_IDLE : S_REQ;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs line up with the state
    always_comb begin
        w_row_show   = (r_state == S_DRAW) ? ({1'b0, r_row} + 8'd1) : 8'd0;
        w_colour_nxt = FLOOR_COLOUR;
        if (w_row_show < w_top)      w_colour_nxt = CEIL_COLOUR;
        else if (w_row_show < w_bot) w_colour_nxt = WALL_COLOUR;
        w_plot_nxt  = (w_state_nxt == S_DRAW);
        w_begin_nxt = (w_state_nxt == S_REQ);
        w_busy_nxt  = (w_state_nxt != S_IDLE);
        w_done_nxt  = (r_state == S_NEXT) && w_col_last;
    end

    // Output registers; pixel fields only load when the next cycle is a plot
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_vga_x  <= 8'd0;
            r_colour <= 3'd0;
            r_plot   <= 1'b0;
            r_begin  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            if (w_plot_nxt) begin
                r_vga_x  <= r_column;
                r_colour <= w_colour_nxt;
            end
            r_plot  <= w_plot_nxt;
            r_begin <= w_begin_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Column, row, timeout and height datapath
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_column <= 8'd0;
            r_row    <= 7'd0;
            r_tmo    <= 8'd0;
            r_h      <= 7'd0;
        end else begin
            case (r_state)
                S_IDLE: if (start_frame) r_column <= 8'd0;
                S_REQ:  r_tmo <= 8'd0;
                S_WAIT: begin
                    if (end_calc)       r_h <= slice_size;
                    else if (w_tmo_hit) r_h <= 7'd0;
                    else                r_tmo <= w_tmo_inc;
                end
                S_SPAN: r_row <= 7'd0;
                S_DRAW: r_row <= (r_row == ROW_LAST) ? 7'd0 : r_row + 7'd1;
                S_NEXT: r_column <= w_col_last ? 8'd0 : r_column + 8'd1;
                default: ;
            endcase
        end
    end

    assign begin_calc   = r_begin;
    assign column_count = r_column;
    assign vga_x        = r_vga_x;
    assign vga_y        = r_row;
    assign vga_colour   = r_colour;
    assign vga_plot     = r_plot;
    assign busy         = r_busy;
    assign frame_done   = r_done;

endmodule

// File: tb/tb_slice_column_renderer.sv
// Bench for slice_column_renderer: bench-side find_slice_height responder with
// per-column delay/height tables, and a pixel-level reference of the column image.
module tb_slice_column_renderer;

    localparam int W   = 160;
    localparam int H   = 120;
    localparam int TMO = 255;
    localparam logic [2:0] C_CEIL  = 3'b001;
    localparam logic [2:0] C_WALL  = 3'b111;
    localparam logic [2:0] C_FLOOR = 3'b010;

    logic       clock = 1'b0;
    logic       resetn = 1'b1;
    logic       start_frame = 1'b0;
    logic [6:0] slice_size = 7'd0;
    logic       end_calc = 1'b0;
    logic       begin_calc;
    logic [7:0] column_count;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       frame_done;

    slice_column_renderer dut (
        .clock        (clock),
        .resetn       (resetn),
        .start_frame  (start_frame),
        .slice_size   (slice_size),
        .end_calc     (end_calc),
        .begin_calc   (begin_calc),
        .column_count (column_count),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .vga_plot     (vga_plot),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int cfg_delay [W];
    int cfg_slice [W];
    int next_col, cur_col, row_cnt, t_req, t_last_plot, exp_h, exp_wait;
    bit have_col, noise_en;
    int begin_cnt, plot_cnt, done_cnt;
    bit resp_active;
    int resp_cnt, resp_delay, resp_slice;
    bit hit;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Column image: clamp height to the screen, split the leftover rows,
    // ceiling gets the smaller half.
    function automatic logic [2:0] ref_colour(input int h, input int row);
        int wall, ceil_rows;
        wall = (h > H) ? H : h;
        ceil_rows = (H - wall) / 2;
        if (row < ceil_rows) return C_CEIL;
        if (row < ceil_rows + wall) return C_WALL;
        return C_FLOOR;
    endfunction

    task reset_model();
        next_col = 0;
        cur_col = 0;
        row_cnt = 0;
        have_col = 0;
        resp_active = 0;
        resp_cnt = 0;
        begin_cnt = 0;
        plot_cnt = 0;
        done_cnt = 0;
    endtask

    task check_idle(input string tag);
        check({tag, "_begin"}, 32'(begin_calc), 0);
        check({tag, "_col"},   32'(column_count), 0);
        check({tag, "_x"},     32'(vga_x), 0);
        check({tag, "_y"},     32'(vga_y), 0);
        check({tag, "_clr"},   32'(vga_colour), 0);
        check({tag, "_plot"},  32'(vga_plot), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_done"},  32'(frame_done), 0);
    endtask

    // One cycle: sample at the falling edge, check, then drive the responder.
    task tick();
        @(negedge clock);
        cyc++;
        if (frame_done) begin
            done_cnt++;
            check("done_last_col", cur_col, W - 1);
            check("done_rows", row_cnt, H);
            check("done_latency", cyc - t_last_plot, 2);
        end
        if (begin_calc) begin
            begin_cnt++;
            if (have_col) check("col_rows", row_cnt, H);
            check("col_order", 32'(column_count), next_col);
            check("busy_req", 32'(busy), 1);
            cur_col = next_col;
            next_col = (next_col + 1) % W;
            have_col = 1;
            row_cnt = 0;
            t_req = cyc;
            resp_delay = cfg_delay[cur_col];
            resp_slice = cfg_slice[cur_col];
            exp_h = (resp_delay <= TMO) ? resp_slice : 0;
            exp_wait = (resp_delay <= TMO) ? resp_delay : TMO;
            resp_active = 1;
            resp_cnt = 0;
        end else if (resp_active) begin
            resp_cnt++;
        end
        if (vga_plot) begin
            plot_cnt++;
            if (row_cnt == 0) check("first_plot_latency", cyc - t_req, exp_wait + 2);
            check("vga_x", 32'(vga_x), cur_col);
            check("vga_y", 32'(vga_y), row_cnt);
            check("colour", 32'(vga_colour), 32'(ref_colour(exp_h, row_cnt)));
            row_cnt++;
            t_last_plot = cyc;
        end
        if (resp_active && resp_cnt == resp_delay) begin
            end_calc = 1'b1;
            slice_size = 7'(resp_slice);
            resp_active = 0;
        end else if (noise_en && vga_plot) begin
            end_calc = 1'($urandom_range(1));
            slice_size = 7'($urandom);
        end else begin
            end_calc = 1'b0;
            slice_size = 7'($urandom);
        end
    endtask

    initial begin
        noise_en = 0;
        t_last_plot = 0;
        for (int i = 0; i < W; i++) begin
            cfg_delay[i] = 1;
            cfg_slice[i] = 0;
        end
        reset_model();

        // Power-on reset
        #2 resetn = 1'b0;
        #1 check_idle("por");
        repeat (2) tick();
        resetn = 1'b1;
        reset_model();
        repeat (4) tick();
        check("idle_no_req", begin_cnt, 0);
        check("idle_busy", 32'(busy), 0);

        // Frame A: boundary heights, timeout, end_calc on the timeout edge; reset at column 5 row 40
        for (int i = 0; i < W; i++) begin
            cfg_delay[i] = $urandom_range(1, 30);
            cfg_slice[i] = $urandom_range(0, 127);
        end
        cfg_delay[0] = 20;   cfg_slice[0] = 40;
        cfg_slice[1] = 127;
        cfg_slice[2] = 0;
        cfg_delay[3] = 1000;
        cfg_delay[4] = TMO;  cfg_slice[4] = $urandom_range(0, 63) * 2 + 1;
        start_frame = 1'b1;
        tick();
        start_frame = 1'b0;
        hit = 0;
        for (int k = 0; k < 5000 && !hit; k++) begin
            tick();
            hit = vga_plot && (vga_x == 8'd5) && (vga_y == 7'd40);
        end
        check("reach_col5_row40", 32'(hit), 1);
        check("frameA_reqs", begin_cnt, 6);
        resetn = 1'b0;
        #1 check_idle("mid_rst");
        tick();
        check_idle("mid_rst_next");
        check("abort_no_done", done_cnt, 0);
        resetn = 1'b1;
        reset_model();
        repeat (3) tick();
        check("post_abort_idle", begin_cnt, 0);

        // Frame B: random heights, late end_calc, spurious end_calc and start_frame while busy
        for (int i = 0; i < W; i++) begin
            cfg_delay[i] = $urandom_range(1, 40);
            cfg_slice[i] = $urandom_range(0, 127);
        end
        cfg_delay[2] = TMO + 1;
        cfg_delay[3] = TMO;
        noise_en = 1;
        start_frame = 1'b1;
        tick();
        for (int k = 0; k < 8000 && begin_cnt < 14; k++) begin
            start_frame = ($urandom_range(3) == 0);
            tick();
        end
        check("frameB_reqs", begin_cnt, 14);
        check("frameB_no_done", done_cnt, 0);
        start_frame = 1'b0;
        noise_en = 0;
        resetn = 1'b0;
        #1 check_idle("frameB_rst");
        tick();
        resetn = 1'b1;
        reset_model();
        repeat (2) tick();

        // Frame C: full frame, constant height 41, start_frame held high (back-to-back)
        for (int i = 0; i < W; i++) begin
            cfg_delay[i] = $urandom_range(1, 4);
            cfg_slice[i] = 41;
        end
        start_frame = 1'b1;
        for (int k = 0; k < 40000 && done_cnt == 0; k++) tick();
        check("full_done", done_cnt, 1);
        check("full_reqs", begin_cnt, W);
        check("full_plots", plot_cnt, W * H);
        tick();
        check("restart_begin", 32'(begin_calc), 1);
        check("restart_col", 32'(column_count), 0);
        check("restart_reqs", begin_cnt, W + 1);
        start_frame = 1'b0;
        repeat (3) tick();
        check("one_done_only", done_cnt, 1);
        resetn = 1'b0;
        #1 check_idle("final_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
